// File: rtl/retire_commit_ctrl_pkg.sv
// Shared types and sizing for the retire/commit controller.
//   - lane, register, ROB index and counter widths
//   - rob_entry_t: one ROB head entry as seen by retire
//   - retire_state_t / stop_reason_t: FSM state and scan stop cause
//   - helpers for branch mispredict detection and the recovery PC
package retire_commit_ctrl_pkg;

  localparam int N              = 4;
  localparam int PHYS_REGS      = 48;
  localparam int PRW            = $clog2(PHYS_REGS);
  localparam int ST_PORTS       = 2;
  localparam int RECOVER_CYCLES = 2;
  localparam int CNT_W          = 64;
  localparam int ROB_IDX_W      = 5;
  localparam int REG_IDX_W      = 5;
  localparam int ADDR_W         = 32;

  localparam int RET_CNT_W = $clog2(N + 1);
  localparam int SQ_CNT_W  = $clog2(ST_PORTS + 1);
  localparam int REC_CNT_W = $clog2(RECOVER_CYCLES + 1);
  localparam int LANE_W    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {RUN, RECOVER, HALTED} retire_state_t;

  typedef enum logic [2:0] {
    STOP_NONE,
    STOP_DISABLED,
    STOP_INVALID,
    STOP_INCOMPLETE,
    STOP_SQ_FULL,
    STOP_MISPRED,
    STOP_HALT
  } stop_reason_t;

  typedef struct packed {
    logic                 complete;
    logic                 is_store;
    logic                 halt;
    logic                 is_branch;
    logic                 pred_taken;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pred_target;
    logic [ADDR_W-1:0]    branch_target;
    logic [REG_IDX_W-1:0] arch_rd;
    logic [PRW-1:0]       phys_rd;
    logic [PRW-1:0]       prev_phys_rd;
  } rob_entry_t;

  // A taken branch with the right direction but a stale target is still wrong.
  function automatic logic is_mispredict(input rob_entry_t e);
    return e.is_branch &&
           ((e.pred_taken != e.branch_taken) ||
            (e.branch_taken && (e.pred_target != e.branch_target)));
  endfunction

  function automatic logic [ADDR_W-1:0] recovery_pc(input rob_entry_t e);
    return e.branch_taken ? e.branch_target : e.pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/retire_commit_ctrl_if.sv
// Bundle between the ROB head window / arch state and the retire controller.
//   master : ROB side, drives the head window and SQ credits, sees commit results
//   slave  : retire controller
// Signals:
//   head_entries/head_valids/head_idxs  ROB head window, [0] oldest
//   sq_credits                          stores the SQ accepts this cycle
//   retire_count, sq_commit_count       pops / store commits this cycle
//   rob_mispredict, rob_mispred_idx     flush younger than the committed branch
//   bp_recover_en, redirect_pc          predictor recovery pulse and fetch target
//   free_mask                           Told registers released this cycle
//   arch_write_*                        per-lane archMapTable update
//   recovering, halted, instret, mispred_cnt  registered status / perf counters
interface retire_commit_ctrl_if;
  import retire_commit_ctrl_pkg::*;

  rob_entry_t [N-1:0]                head_entries;
  logic [N-1:0]                      head_valids;
  logic [N-1:0][ROB_IDX_W-1:0]       head_idxs;
  logic [SQ_CNT_W-1:0]               sq_credits;

  logic [RET_CNT_W-1:0]              retire_count;
  logic [SQ_CNT_W-1:0]               sq_commit_count;
  logic                              rob_mispredict;
  logic [ROB_IDX_W-1:0]              rob_mispred_idx;
  logic                              bp_recover_en;
  logic [ADDR_W-1:0]                 redirect_pc;
  logic [PHYS_REGS-1:0]              free_mask;
  logic [N-1:0]                      arch_write_enables;
  logic [N-1:0][REG_IDX_W-1:0]       arch_write_addrs;
  logic [N-1:0][PRW-1:0]             arch_write_phys_regs;
  logic                              recovering;
  logic                              halted;
  logic [CNT_W-1:0]                  instret;
  logic [CNT_W-1:0]                  mispred_cnt;

  modport master (
    output head_entries, head_valids, head_idxs, sq_credits,
    input  retire_count, sq_commit_count, rob_mispredict, rob_mispred_idx,
           bp_recover_en, redirect_pc, free_mask, arch_write_enables,
           arch_write_addrs, arch_write_phys_regs, recovering, halted,
           instret, mispred_cnt
  );

  modport slave (
    input  head_entries, head_valids, head_idxs, sq_credits,
    output retire_count, sq_commit_count, rob_mispredict, rob_mispred_idx,
           bp_recover_en, redirect_pc, free_mask, arch_write_enables,
           arch_write_addrs, arch_write_phys_regs, recovering, halted,
           instret, mispred_cnt
  );

endinterface

// File: rtl/retire_commit_ctrl_lane_select.sv
// Combinational in-order prefix scan over the head window.
// Ports:
//   enable       scan allowed (RUN and not in reset)
//   valids, complete, is_store, halt, mispred   per-lane flags, [0] oldest
//   sq_credits   store commits the SQ accepts this cycle
//   commit_mask  contiguous-from-lane-0 commit set
//   store_count  stores inside commit_mask
//   mispred_lane lane of the committed mispredicted branch
//   stop_reason  why the scan ended
module retire_commit_ctrl_lane_select
  import retire_commit_ctrl_pkg::*;
(
  input  logic                enable,
  input  logic [N-1:0]        valids,
  input  logic [N-1:0]        complete,
  input  logic [N-1:0]        is_store,
  input  logic [N-1:0]        halt,
  input  logic [N-1:0]        mispred,
  input  logic [SQ_CNT_W-1:0] sq_credits,
  output logic [N-1:0]        commit_mask,
  output logic [SQ_CNT_W-1:0] store_count,
  output logic [LANE_W-1:0]   mispred_lane,
  output stop_reason_t        stop_reason
);

  logic                blocked;
  logic [SQ_CNT_W-1:0] credit_lim;

  // The SQ never takes more than ST_PORTS stores in one cycle, whatever it offers.
  assign credit_lim = (sq_credits > SQ_CNT_W'(ST_PORTS)) ? SQ_CNT_W'(ST_PORTS) : sq_credits;

  always_comb begin
    commit_mask  = '0;
    store_count  = '0;
    mispred_lane = '0;
    stop_reason  = enable ? STOP_NONE : STOP_DISABLED;
    blocked      = !enable;
    for (int w = 0; w < N; w++) begin
      if (!blocked) begin
        if (!valids[w]) begin
          blocked     = 1'b1;
          stop_reason = STOP_INVALID;
        end else if (!complete[w]) begin
          blocked     = 1'b1;
          stop_reason = STOP_INCOMPLETE;
        end else if (is_store[w] && (store_count == credit_lim)) begin
          blocked     = 1'b1;
          stop_reason = STOP_SQ_FULL;
        end else begin
          commit_mask[w] = 1'b1;
          if (is_store[w]) store_count = store_count + SQ_CNT_W'(1);
          // Mispredict and halt both commit their own lane but fence younger ones.
          if (mispred[w]) begin
            blocked      = 1'b1;
            stop_reason  = STOP_MISPRED;
            mispred_lane = LANE_W'(w);
          end else if (halt[w]) begin
            blocked     = 1'b1;
            stop_reason = STOP_HALT;
          end
        end
      end
    end
  end

endmodule

// File: rtl/retire_commit_ctrl.sv
// N-wide in-order retire controller between the ROB head window and arch
// state. Commit outputs are combinational from the window and FSM state;
// status flags and perf counters are registered.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    retire_commit_ctrl_if.slave (head window in, commit results out)
//
// state   | meaning
// RUN     | scanning and committing the head window every cycle
// RECOVER | post-mispredict bubble, down-counter runs to terminal count
// HALTED  | HALT retired, nothing commits until reset
module retire_commit_ctrl
  import retire_commit_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  retire_commit_ctrl_if.slave   bus
);

  retire_state_t        state;
  logic [REC_CNT_W-1:0] recover_cnt;
  logic                 recovering_q;
  logic                 halted_q;
  logic [CNT_W-1:0]     instret_q;
  logic [CNT_W-1:0]     mispred_cnt_q;

  logic [N-1:0]         lane_complete;
  logic [N-1:0]         lane_store;
  logic [N-1:0]         lane_halt;
  logic [N-1:0]         lane_mispred;
  logic [N-1:0]         commit_mask;
  logic [SQ_CNT_W-1:0]  store_count;
  logic [LANE_W-1:0]    mispred_lane;
  stop_reason_t         stop_reason;
  logic                 scan_en;
  logic                 mispred_commit;
  logic [RET_CNT_W-1:0] retire_cnt;

  always_comb begin
    lane_complete = '0;
    lane_store    = '0;
    lane_halt     = '0;
    lane_mispred  = '0;
    for (int w = 0; w < N; w++) begin
      lane_complete[w] = bus.head_entries[w].complete;
      lane_store[w]    = bus.head_entries[w].is_store;
      lane_halt[w]     = bus.head_entries[w].halt;
      lane_mispred[w]  = is_mispredict(bus.head_entries[w]);
    end
  end

  // Reset also gates the scan so every commit output reads zero during reset.
  assign scan_en = !reset && (state == RUN);

  retire_commit_ctrl_lane_select u_lane_select (
    .enable       (scan_en),
    .valids       (bus.head_valids),
    .complete     (lane_complete),
    .is_store     (lane_store),
    .halt         (lane_halt),
    .mispred      (lane_mispred),
    .sq_credits   (bus.sq_credits),
    .commit_mask  (commit_mask),
    .store_count  (store_count),
    .mispred_lane (mispred_lane),
    .stop_reason  (stop_reason)
  );

  assign mispred_commit = (stop_reason == STOP_MISPRED);

  always_comb begin
    retire_cnt               = '0;
    bus.arch_write_enables   = '0;
    bus.arch_write_addrs     = '0;
    bus.arch_write_phys_regs = '0;
    bus.free_mask            = '0;
    for (int w = 0; w < N; w++) begin
      retire_cnt = retire_cnt + RET_CNT_W'(commit_mask[w]);
      // arch_rd==0 lanes retire without touching the map or the freelist.
      if (commit_mask[w] && (bus.head_entries[w].arch_rd != '0)) begin
        bus.arch_write_enables[w]   = 1'b1;
        bus.arch_write_addrs[w]     = bus.head_entries[w].arch_rd;
        bus.arch_write_phys_regs[w] = bus.head_entries[w].phys_rd;
        if ((bus.head_entries[w].prev_phys_rd != '0) &&
            (int'(bus.head_entries[w].prev_phys_rd) < PHYS_REGS))
          bus.free_mask[bus.head_entries[w].prev_phys_rd] = 1'b1;
      end
    end
  end

  assign bus.retire_count    = retire_cnt;
  assign bus.sq_commit_count = store_count;
  assign bus.rob_mispredict  = mispred_commit;
  assign bus.bp_recover_en   = mispred_commit;
  assign bus.rob_mispred_idx = mispred_commit ? bus.head_idxs[mispred_lane] : '0;
  assign bus.redirect_pc     = mispred_commit ? recovery_pc(bus.head_entries[mispred_lane]) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      recover_cnt   <= '0;
      recovering_q  <= 1'b0;
      halted_q      <= 1'b0;
      instret_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      instret_q <= instret_q + CNT_W'(retire_cnt);
      if (mispred_commit) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      unique case (state)
        RUN: begin
          if (mispred_commit) begin
            state        <= RECOVER;
            recover_cnt  <= REC_CNT_W'(RECOVER_CYCLES);
            recovering_q <= 1'b1;
          end else if (stop_reason == STOP_HALT) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        RECOVER: begin
          recover_cnt <= recover_cnt - REC_CNT_W'(1);
          if (recover_cnt == REC_CNT_W'(1)) begin
            state        <= RUN;
            recovering_q <= 1'b0;
          end
        end
        HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state        <= RUN;
          recovering_q <= 1'b0;
          halted_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.recovering  = recovering_q;
  assign bus.halted      = halted_q;
  assign bus.instret     = instret_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_retire_commit_ctrl.sv
module tb_retire_commit_ctrl;
  import retire_commit_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  retire_commit_ctrl_if bus();

  retire_commit_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: 0 = committing, 1 = recovery bubble, 2 = halted
  int          m_mode = 0;
  int          m_left = 0;
  logic [63:0] m_instret = '0;
  logic [63:0] m_mispred = '0;

  // expected combinational results for the current window
  int                          e_retire;
  int                          e_sq;
  bit                          e_mp;
  bit                          e_halt;
  logic [ROB_IDX_W-1:0]        e_idx;
  logic [31:0]                 e_pc;
  logic [PHYS_REGS-1:0]        e_free;
  logic [N-1:0]                e_we;
  logic [N-1:0][REG_IDX_W-1:0] e_addr;
  logic [N-1:0][PRW-1:0]       e_phys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the window oldest-first, retiring until something stops it.
  task automatic model_comb();
    rob_entry_t e;
    int         credits;
    bit         done;
    bit         wrong;
    e_retire = 0; e_sq = 0; e_mp = 0; e_halt = 0; e_idx = '0; e_pc = '0;
    e_free = '0; e_we = '0; e_addr = '0; e_phys = '0;
    done = (reset !== 1'b0) || (m_mode != 0);
    credits = (int'(bus.sq_credits) > ST_PORTS) ? ST_PORTS : int'(bus.sq_credits);
    for (int w = 0; w < N; w++) begin
      e = bus.head_entries[w];
      if (!done) begin
        if (!bus.head_valids[w] || !e.complete) done = 1;
        else if (e.is_store && e_sq == credits) done = 1;
        else begin
          e_retire++;
          if (e.is_store) e_sq++;
          if (e.arch_rd != 0) begin
            e_we[w] = 1'b1;
            e_addr[w] = e.arch_rd;
            e_phys[w] = e.phys_rd;
            if (e.prev_phys_rd != 0 && int'(e.prev_phys_rd) < PHYS_REGS)
              e_free[e.prev_phys_rd] = 1'b1;
          end
          wrong = e.is_branch && ((e.pred_taken != e.branch_taken) ||
                                  (e.branch_taken && e.pred_target != e.branch_target));
          if (wrong) begin
            e_mp = 1; e_idx = bus.head_idxs[w];
            e_pc = e.branch_taken ? e.branch_target : e.pc + 32'd4;
            done = 1;
          end else if (e.halt) begin
            e_halt = 1; done = 1;
          end
        end
      end
    end
  endtask

  task automatic model_seq();
    if (reset) begin
      m_mode = 0; m_left = 0; m_instret = '0; m_mispred = '0;
    end else begin
      m_instret = m_instret + 64'(e_retire);
      if (e_mp) m_mispred = m_mispred + 64'd1;
      if (m_mode == 0) begin
        if (e_mp) begin m_mode = 1; m_left = RECOVER_CYCLES; end
        else if (e_halt) m_mode = 2;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end
  endtask

  task automatic comb_check();
    #1;
    model_comb();
    chk("retire_count", 64'(bus.retire_count), 64'(e_retire));
    chk("sq_commit_count", 64'(bus.sq_commit_count), 64'(e_sq));
    chk("rob_mispredict", 64'(bus.rob_mispredict), 64'(e_mp));
    chk("bp_recover_en", 64'(bus.bp_recover_en), 64'(e_mp));
    chk("rob_mispred_idx", 64'(bus.rob_mispred_idx), 64'(e_idx));
    chk("redirect_pc", 64'(bus.redirect_pc), 64'(e_pc));
    chk("free_mask", 64'(bus.free_mask), 64'(e_free));
    chk("arch_we", 64'(bus.arch_write_enables), 64'(e_we));
    chk("arch_addrs", 64'(bus.arch_write_addrs), 64'(e_addr));
    chk("arch_phys", 64'(bus.arch_write_phys_regs), 64'(e_phys));
  endtask

  task automatic clk_check();
    @(posedge clock);
    model_seq();
    #1;
    chk("recovering", 64'(bus.recovering), 64'(m_mode == 1));
    chk("halted", 64'(bus.halted), 64'(m_mode == 2));
    chk("instret", bus.instret, m_instret);
    chk("mispred_cnt", bus.mispred_cnt, m_mispred);
    @(negedge clock);
  endtask

  function automatic rob_entry_t alu(input logic [4:0] rd, input logic [PRW-1:0] phys,
                                     input logic [PRW-1:0] prev);
    rob_entry_t e;
    e = '0;
    e.complete = 1'b1;
    e.arch_rd = rd;
    e.phys_rd = phys;
    e.prev_phys_rd = prev;
    e.pc = 32'h100;
    return e;
  endfunction

  function automatic rob_entry_t rand_entry();
    rob_entry_t e;
    e = '0;
    e.complete = ($urandom_range(0, 9) < 8);
    e.is_store = ($urandom_range(0, 3) == 0);
    e.is_branch = !e.is_store && ($urandom_range(0, 2) == 0);
    e.branch_taken = 1'($urandom_range(0, 1));
    e.pred_taken = ($urandom_range(0, 9) < 7) ? e.branch_taken : !e.branch_taken;
    e.pc = $urandom & 32'hFFFF_FFFC;
    e.pred_target = $urandom & 32'hFFFF_FFFC;
    e.branch_target = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : e.pred_target;
    e.arch_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    e.phys_rd = PRW'($urandom_range(0, PHYS_REGS - 1));
    e.prev_phys_rd = PRW'($urandom_range(0, 63));
    return e;
  endfunction

  task automatic drive_alu4(input int idx_base);
    for (int w = 0; w < N; w++) begin
      bus.head_entries[w] = alu(5'(w + 1), PRW'(40 + w), PRW'(33 + w));
      bus.head_idxs[w] = ROB_IDX_W'(idx_base + w);
    end
    bus.head_valids = '1;
  endtask

  initial begin
    reset = 1'b1;
    bus.sq_credits = 2'd2;
    drive_alu4(0);
    @(negedge clock);
    comb_check();
    chk("rst_retire", 64'(bus.retire_count), 64'd0);
    chk("rst_we", 64'(bus.arch_write_enables), 64'd0);
    clk_check();
    chk("rst_instret", bus.instret, 64'd0);
    reset = 1'b0;

    // four plain ALU ops
    drive_alu4(0);
    comb_check();
    chk("t1_retire", 64'(bus.retire_count), 64'd4);
    chk("t1_free", 64'(bus.free_mask), 64'h0000_001E_0000_0000);
    clk_check();
    chk("t1_instret", bus.instret, 64'd4);

    // incomplete lane 2 stops the group
    drive_alu4(4);
    bus.head_entries[2].complete = 1'b0;
    comb_check();
    chk("t2_retire", 64'(bus.retire_count), 64'd2);
    chk("t2_we", 64'(bus.arch_write_enables), 64'b0011);
    clk_check();
    chk("t2_instret", bus.instret, 64'd6);

    // lane 1 branch predicted not-taken, actually taken
    drive_alu4(10);
    bus.head_entries[1].is_branch = 1'b1;
    bus.head_entries[1].pred_taken = 1'b0;
    bus.head_entries[1].branch_taken = 1'b1;
    bus.head_entries[1].branch_target = 32'h1000;
    comb_check();
    chk("t3_retire", 64'(bus.retire_count), 64'd2);
    chk("t3_mispredict", 64'(bus.rob_mispredict), 64'd1);
    chk("t3_idx", 64'(bus.rob_mispred_idx), 64'd11);
    chk("t3_pc", 64'(bus.redirect_pc), 64'h1000);
    clk_check();
    chk("t3_recovering", 64'(bus.recovering), 64'd1);
    chk("t3_mispred_cnt", bus.mispred_cnt, 64'd1);
    for (int i = 0; i < 2; i++) begin
      drive_alu4(12);
      comb_check();
      chk("t3_bubble_retire", 64'(bus.retire_count), 64'd0);
      clk_check();
      chk("t3_bubble_recovering", 64'(bus.recovering), 64'(i == 0));
    end
    drive_alu4(12);
    comb_check();
    chk("t3_run_retire", 64'(bus.retire_count), 64'd4);
    clk_check();

    // three stores, SQ credit limited
    drive_alu4(16);
    for (int w = 0; w < 3; w++) begin
      bus.head_entries[w].is_store = 1'b1;
      bus.head_entries[w].arch_rd = 5'd0;
    end
    bus.sq_credits = 2'd1;
    comb_check();
    chk("t4_retire", 64'(bus.retire_count), 64'd1);
    chk("t4_sq", 64'(bus.sq_commit_count), 64'd1);
    clk_check();
    bus.sq_credits = 2'd2;
    comb_check();
    chk("t4b_sq", 64'(bus.sq_commit_count), 64'd2);
    chk("t4b_retire", 64'(bus.retire_count), 64'd2);
    clk_check();

    // duplicate arch_rd, silent rd0, out-of-range and zero prev tags
    bus.head_entries[0] = alu(5'd5, PRW'(41), PRW'(50));
    bus.head_entries[1] = alu(5'd5, PRW'(44), PRW'(0));
    bus.head_entries[2] = alu(5'd0, PRW'(45), PRW'(20));
    bus.head_entries[3] = alu(5'd7, PRW'(46), PRW'(47));
    bus.head_valids = '1;
    comb_check();
    chk("tb_we", 64'(bus.arch_write_enables), 64'b1011);
    chk("tb_free", 64'(bus.free_mask), 64'h0000_8000_0000_0000);
    clk_check();

    // randomized window traffic, no halts
    for (int c = 0; c < 300; c++) begin
      for (int w = 0; w < N; w++) begin
        bus.head_entries[w] = rand_entry();
        bus.head_idxs[w] = ROB_IDX_W'($urandom);
      end
      bus.head_valids = N'($urandom_range(0, 15) | (($urandom_range(0, 3) != 0) ? 15 : 0));
      bus.sq_credits = 2'($urandom_range(0, 3));
      comb_check();
      clk_check();
    end

    bus.head_valids = '0;
    bus.sq_credits = 2'd2;
    for (int i = 0; i < 3; i++) begin comb_check(); clk_check(); end

    // mispredict in lane 0 blocks the halt in lane 1
    drive_alu4(20);
    bus.head_entries[0].is_branch = 1'b1;
    bus.head_entries[0].pred_taken = 1'b1;
    bus.head_entries[0].pc = 32'h400;
    bus.head_entries[1].halt = 1'b1;
    comb_check();
    chk("to_retire", 64'(bus.retire_count), 64'd1);
    chk("to_pc", 64'(bus.redirect_pc), 64'h404);
    clk_check();
    chk("to_halted", 64'(bus.halted), 64'd0);
    bus.head_valids = '0;
    for (int i = 0; i < 2; i++) begin comb_check(); clk_check(); end

    // reset during recovery
    drive_alu4(24);
    bus.head_entries[0].is_branch = 1'b1;
    bus.head_entries[0].branch_taken = 1'b1;
    comb_check();
    clk_check();
    chk("t5_recovering", 64'(bus.recovering), 64'd1);
    reset = 1'b1;
    comb_check();
    chk("t5_rst_pulse", 64'(bus.bp_recover_en), 64'd0);
    clk_check();
    chk("t5_recovering_clr", 64'(bus.recovering), 64'd0);
    chk("t5_instret", bus.instret, 64'd0);
    chk("t5_mispred_cnt", bus.mispred_cnt, 64'd0);
    reset = 1'b0;
    drive_alu4(28);
    comb_check();
    chk("t5_run_retire", 64'(bus.retire_count), 64'd4);
    clk_check();

    // halt in lane 0
    drive_alu4(0);
    bus.head_entries[0].halt = 1'b1;
    comb_check();
    chk("t6_retire", 64'(bus.retire_count), 64'd1);
    clk_check();
    chk("t6_halted", 64'(bus.halted), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_alu4(1);
      comb_check();
      chk("t6_stuck_retire", 64'(bus.retire_count), 64'd0);
      clk_check();
      chk("t6_stuck_halted", 64'(bus.halted), 64'd1);
    end
    reset = 1'b1;
    comb_check();
    clk_check();
    chk("t6_halt_clr", 64'(bus.halted), 64'd0);
    reset = 1'b0;
    drive_alu4(1);
    comb_check();
    chk("t6_run_retire", 64'(bus.retire_count), 64'd4);
    clk_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
